// File: rtl/sweep_core.sv
// sweep_core: minesweeper play core (cursor movement, sweep/flag actions, win/lose detection).
// Define SWEEP_FLOOD_FILL_EN to build the multi-cycle flood reveal of zero-count regions.
module sweep_core #(
   parameter int         MAP_W      = 8,
   parameter int         MAP_H      = 8,
   parameter int         CELL_W     = 4,
   parameter int         MINE_CODE  = 15,
   parameter logic [2:0] PLAY_STATE = 3'd2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [2:0]                       screen_state_i,
   input  logic [4:0]                       button_i,
   input  logic                             fm_switch_i,
   input  logic [CELL_W*MAP_W*MAP_H-1:0]    map_i,
   output logic [$clog2(MAP_W)-1:0]         x_pos_o,
   output logic [$clog2(MAP_H)-1:0]         y_pos_o,
   output logic [1:0]                       play_end_o,
   output logic [MAP_W*MAP_H-1:0]           map_shown_o,
   output logic [MAP_W*MAP_H-1:0]           map_flag_o,
   output logic                             busy_o
);

   localparam int NCELL = MAP_W * MAP_H;
   localparam int IDX_W = $clog2(NCELL);
   localparam int XW    = $clog2(MAP_W);
   localparam int YW    = $clog2(MAP_H);

   localparam logic [1:0] S_IDLE  = 2'd0;
`ifdef SWEEP_FLOOD_FILL_EN
   localparam logic [1:0] S_FLOOD = 2'd1;
`endif
   localparam logic [1:0] S_END   = 2'd2;

   logic [1:0]       r_state;
   logic [4:0]       r_btnPrev;
   logic [XW-1:0]    r_x;
   logic [YW-1:0]    r_y;
   logic [NCELL-1:0] r_shown;
   logic [NCELL-1:0] r_flag;
   logic [1:0]       r_end;

   logic [4:0]       w_edge;
   logic [NCELL-1:0] w_mine;
   logic [IDX_W-1:0] w_curIdx;
   logic             w_curFree;
   logic             w_win;
   logic [XW-1:0]    w_xDec;
   logic [XW-1:0]    w_xInc;
   logic [YW-1:0]    w_yDec;
   logic [YW-1:0]    w_yInc;

   assign w_edge = button_i & ~r_btnPrev;

   for (genvar k = 0; k < NCELL; k++) begin : g_cell
      assign w_mine[k] = (map_i[k*CELL_W +: CELL_W] == CELL_W'(MINE_CODE));
   end

   assign w_curIdx  = IDX_W'(r_y) * IDX_W'(MAP_W) + IDX_W'(r_x);
   assign w_curFree = !r_shown[w_curIdx] && !r_flag[w_curIdx];
   assign w_win     = &(r_shown | w_mine);

   assign w_xDec = (r_x == '0) ? XW'(MAP_W - 1) : r_x - 1'b1;
   assign w_xInc = (r_x == XW'(MAP_W - 1)) ? '0 : r_x + 1'b1;
   assign w_yDec = (r_y == '0) ? YW'(MAP_H - 1) : r_y - 1'b1;
   assign w_yInc = (r_y == YW'(MAP_H - 1)) ? '0 : r_y + 1'b1;

`ifdef SWEEP_FLOOD_FILL_EN
   logic [IDX_W-1:0] r_idx;
   logic             r_passHit;
   logic [NCELL-1:0] w_zero;
   logic [NCELL-1:0] w_zeroShown;
   logic [NCELL-1:0] w_nbrHit;
   logic             w_scanHit;

   // True when any in-map 8-neighbour of (cx,cy) is a revealed zero cell.
   function automatic logic zeroNeighbour(input int cx, input int cy, input logic [NCELL-1:0] zs);
      logic hit;
      hit = 1'b0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            if ((dx != 0 || dy != 0) && (cx + dx >= 0) && (cx + dx < MAP_W) &&
                (cy + dy >= 0) && (cy + dy < MAP_H)) begin
               hit = hit | zs[IDX_W'((cy + dy) * MAP_W + cx + dx)];
            end
         end
      end
      return hit;
   endfunction

   for (genvar k = 0; k < NCELL; k++) begin : g_zero
      assign w_zero[k] = (map_i[k*CELL_W +: CELL_W] == '0);
   end

   assign w_zeroShown = r_shown & w_zero;

   for (genvar gy = 0; gy < MAP_H; gy++) begin : g_row
      for (genvar gx = 0; gx < MAP_W; gx++) begin : g_col
         assign w_nbrHit[gy*MAP_W+gx] = zeroNeighbour(gx, gy, w_zeroShown);
      end
   end

   assign w_scanHit = !r_shown[r_idx] && !r_flag[r_idx] && !w_mine[r_idx] && w_nbrHit[r_idx];
   assign busy_o    = (r_state == S_FLOOD);
`else
   assign busy_o    = 1'b0;
`endif

   // Leaving the play screen clears everything just like reset; a lose found in the
   // same cycle as a win takes precedence, and a win drops any other button action.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_btnPrev <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_shown   <= '0;
         r_flag    <= '0;
         r_end     <= '0;
`ifdef SWEEP_FLOOD_FILL_EN
         r_idx     <= '0;
         r_passHit <= 1'b0;
`endif
      end else if (screen_state_i != PLAY_STATE) begin
         r_state   <= S_IDLE;
         r_btnPrev <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_shown   <= '0;
         r_flag    <= '0;
         r_end     <= '0;
`ifdef SWEEP_FLOOD_FILL_EN
         r_idx     <= '0;
         r_passHit <= 1'b0;
`endif
      end else begin
         r_btnPrev <= button_i;
         case (r_state)
            S_IDLE: begin
               if (w_edge[4] && !fm_switch_i && w_curFree && w_mine[w_curIdx]) begin
                  r_shown[w_curIdx] <= 1'b1;
                  r_end             <= 2'b01;
                  r_state           <= S_END;
               end else if (w_win) begin
                  r_end   <= 2'b10;
                  r_state <= S_END;
               end else if (w_edge[4]) begin
                  if (fm_switch_i) begin
                     if (!r_shown[w_curIdx]) begin
                        r_flag[w_curIdx] <= ~r_flag[w_curIdx];
                     end
                  end else if (w_curFree) begin
                     r_shown[w_curIdx] <= 1'b1;
`ifdef SWEEP_FLOOD_FILL_EN
                     if (w_zero[w_curIdx]) begin
                        r_idx     <= '0;
                        r_passHit <= 1'b0;
                        r_state   <= S_FLOOD;
                     end
`endif
                  end
               end else if (w_edge[0]) begin
                  r_y <= w_yDec;
               end else if (w_edge[1]) begin
                  r_y <= w_yInc;
               end else if (w_edge[2]) begin
                  r_x <= w_xDec;
               end else if (w_edge[3]) begin
                  r_x <= w_xInc;
               end
            end
`ifdef SWEEP_FLOOD_FILL_EN
            // One cell per cycle; a pass that revealed anything is repeated from cell 0.
            S_FLOOD: begin
               if (w_win) begin
                  r_end   <= 2'b10;
                  r_state <= S_END;
               end else begin
                  if (w_scanHit) begin
                     r_shown[r_idx] <= 1'b1;
                  end
                  if (r_idx == IDX_W'(NCELL - 1)) begin
                     r_idx     <= '0;
                     r_passHit <= 1'b0;
                     if (!(r_passHit || w_scanHit)) begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_idx <= r_idx + 1'b1;
                     if (w_scanHit) begin
                        r_passHit <= 1'b1;
                     end
                  end
               end
            end
`endif
            S_END: begin
               r_state <= S_END;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign x_pos_o     = r_x;
   assign y_pos_o     = r_y;
   assign play_end_o  = r_end;
   assign map_shown_o = r_shown;
   assign map_flag_o  = r_flag;

endmodule

// File: tb/tb_sweep_core.sv
// Self-checking bench for sweep_core: directed scenarios plus randomized play against a
// cell-array model of the game rules. Follows SWEEP_FLOOD_FILL_EN like the design.
module tb_sweep_core;
   localparam int W    = 8;
   localparam int H    = 8;
   localparam int NC   = W * H;
   localparam int MINE = 15;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [2:0]      screenState;
   logic [4:0]      buttons;
   logic            fmSwitch;
   logic [4*NC-1:0] mapBus;
   logic [2:0]      xPos;
   logic [2:0]      yPos;
   logic [1:0]      playEnd;
   logic [NC-1:0]   shown;
   logic [NC-1:0]   flag;
   logic            busy;

   int nChecks = 0;
   int nErrors = 0;

   int   cellv[NC];
   bit   mineSet[NC];

   int   mx, my, mmode, fidx;
   bit   fhit;
   bit   mshown[NC];
   bit   mflag[NC];
   logic [1:0] mend;
   logic [4:0] mprev;

   always #5 clk = ~clk;

   sweep_core dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .screen_state_i (screenState),
      .button_i       (buttons),
      .fm_switch_i    (fmSwitch),
      .map_i          (mapBus),
      .x_pos_o        (xPos),
      .y_pos_o        (yPos),
      .play_end_o     (playEnd),
      .map_shown_o    (shown),
      .map_flag_o     (flag),
      .busy_o         (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Counts come from the mine layout so the map is always self-consistent.
   task automatic buildMap();
      for (int k = 0; k < NC; k++) begin
         int cnt;
         cnt = 0;
         if (mineSet[k]) begin
            cellv[k] = MINE;
         end else begin
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  int nx, ny;
                  nx = k % W + dx;
                  ny = k / W + dy;
                  if ((dx != 0 || dy != 0) && nx >= 0 && nx < W && ny >= 0 && ny < H && mineSet[ny*W+nx]) begin
                     cnt++;
                  end
               end
            end
            cellv[k] = cnt;
         end
         mapBus[k*4 +: 4] = 4'(cellv[k]);
      end
   endtask

   task automatic modelReset();
      mx = 0; my = 0; mmode = 0; fidx = 0; fhit = 1'b0;
      mend = 2'b00; mprev = 5'b0;
      for (int k = 0; k < NC; k++) begin
         mshown[k] = 1'b0;
         mflag[k]  = 1'b0;
      end
   endtask

   function automatic bit allSafeShown();
      for (int k = 0; k < NC; k++) begin
         if (cellv[k] != MINE && !mshown[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit zeroShownNeighbour(input int k);
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            nx = k % W + dx;
            ny = k / W + dy;
            if ((dx != 0 || dy != 0) && nx >= 0 && nx < W && ny >= 0 && ny < H) begin
               if (mshown[ny*W+nx] && cellv[ny*W+nx] == 0) return 1'b1;
            end
         end
      end
      return 1'b0;
   endfunction

   // One clock edge of the game rules; mmode 0 = idle, 1 = flooding, 2 = game over.
   task automatic modelStep(input logic [2:0] s, input logic [4:0] b, input logic fm);
      logic [4:0] e;
      bit win;
      int k;
      if (s != 3'd2) begin
         modelReset();
         return;
      end
      e = b & ~mprev;
      mprev = b;
      win = allSafeShown();
      k = my * W + mx;
      if (mmode == 0) begin
         if (e[4] && !fm && !mshown[k] && !mflag[k] && cellv[k] == MINE) begin
            mshown[k] = 1'b1; mend = 2'b01; mmode = 2;
         end else if (win) begin
            mend = 2'b10; mmode = 2;
         end else if (e[4]) begin
            if (fm) begin
               if (!mshown[k]) mflag[k] = !mflag[k];
            end else if (!mshown[k] && !mflag[k]) begin
               mshown[k] = 1'b1;
`ifdef SWEEP_FLOOD_FILL_EN
               if (cellv[k] == 0) begin
                  mmode = 1; fidx = 0; fhit = 1'b0;
               end
`endif
            end
         end else if (e[0]) my = (my + H - 1) % H;
         else if (e[1]) my = (my + 1) % H;
         else if (e[2]) mx = (mx + W - 1) % W;
         else if (e[3]) mx = (mx + 1) % W;
      end else if (mmode == 1) begin
         if (win) begin
            mend = 2'b10; mmode = 2;
         end else begin
            if (!mshown[fidx] && !mflag[fidx] && cellv[fidx] != MINE && zeroShownNeighbour(fidx)) begin
               mshown[fidx] = 1'b1;
               fhit = 1'b1;
            end
            if (fidx == NC - 1) begin
               if (fhit) begin
                  fidx = 0; fhit = 1'b0;
               end else begin
                  mmode = 0;
               end
            end else begin
               fidx++;
            end
         end
      end
   endtask

   task automatic checkOutput();
      logic [63:0] expShown, expFlag;
      for (int k = 0; k < NC; k++) begin
         expShown[k] = mshown[k];
         expFlag[k]  = mflag[k];
      end
      chk("cursor x", 64'(xPos), 64'(mx));
      chk("cursor y", 64'(yPos), 64'(my));
      chk("play_end", 64'(playEnd), 64'(mend));
      chk("map_shown", 64'(shown), expShown);
      chk("map_flag", 64'(flag), expFlag);
      chk("busy", 64'(busy), 64'(mmode == 1));
   endtask

   task automatic applyStimulus(input logic [2:0] s, input logic [4:0] b, input logic fm);
      screenState = s;
      buttons     = b;
      fmSwitch    = fm;
      @(posedge clk);
      modelStep(s, b, fm);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic press(input int bitn, input logic fm);
      applyStimulus(3'd2, 5'(1 << bitn), fm);
      applyStimulus(3'd2, 5'b0, fm);
   endtask

   initial begin
      rst_n = 1'b0;
      screenState = 3'd0;
      buttons = 5'b0;
      fmSwitch = 1'b0;
      for (int k = 0; k < NC; k++) mineSet[k] = 1'b0;
      mineSet[45] = 1'b1;
      buildMap();
      modelReset();
      repeat (2) @(negedge clk);
      chk("reset x", 64'(xPos), 64'd0);
      chk("reset y", 64'(yPos), 64'd0);
      chk("reset end", 64'(playEnd), 64'd0);
      chk("reset shown", 64'(shown), 64'd0);
      chk("reset flag", 64'(flag), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      rst_n = 1'b1;

      // Cursor wrap and flag toggling.
      applyStimulus(3'd2, 5'b0, 1'b0);
      press(2, 1'b0);
      chk("left wrap x", 64'(xPos), 64'd7);
      chk("left wrap y", 64'(yPos), 64'd0);
      press(0, 1'b0);
      chk("up wrap y", 64'(yPos), 64'd7);
      repeat (3) press(3, 1'b0);
      repeat (4) press(0, 1'b0);
      chk("at (2,3) x", 64'(xPos), 64'd2);
      chk("at (2,3) y", 64'(yPos), 64'd3);
      press(4, 1'b1);
      chk("flag set 26", 64'(flag), 64'h0000_0000_0400_0000);
      press(4, 1'b1);
      chk("flag clear 26", 64'(flag), 64'd0);
      press(4, 1'b1);
      press(4, 1'b0);
      chk("sweep flagged shown", 64'(shown), 64'd0);
      chk("sweep flagged flag", 64'(flag), 64'h0000_0000_0400_0000);

      // Sweeping the mine at (5,5) loses on the same edge; later edges ignored.
      repeat (3) press(3, 1'b0);
      repeat (2) press(1, 1'b0);
      applyStimulus(3'd2, 5'b10000, 1'b0);
      chk("mine shown 45", 64'(shown), 64'h0000_2000_0000_0000);
      chk("lose end", 64'(playEnd), 64'd1);
      applyStimulus(3'd2, 5'b0, 1'b0);
      press(0, 1'b0);
      chk("after lose y", 64'(yPos), 64'd5);
      chk("after lose end", 64'(playEnd), 64'd1);

      applyStimulus(3'd0, 5'b0, 1'b0);
      chk("clear shown", 64'(shown), 64'd0);
      chk("clear end", 64'(playEnd), 64'd0);

      // Single mine in the far corner, sweep the opposite corner.
      for (int k = 0; k < NC; k++) mineSet[k] = 1'b0;
      mineSet[63] = 1'b1;
      buildMap();
      applyStimulus(3'd2, 5'b0, 1'b0);
      applyStimulus(3'd2, 5'b10000, 1'b0);
`ifdef SWEEP_FLOOD_FILL_EN
      chk("flood busy start", 64'(busy), 64'd1);
      applyStimulus(3'd2, 5'b01000, 1'b0);
      chk("right during flood", 64'(xPos), 64'd0);
      begin
         int guard;
         guard = 0;
         while (busy && guard < 5000) begin
            applyStimulus(3'd2, 5'b0, 1'b0);
            guard++;
         end
      end
      chk("flood finished", 64'(busy), 64'd0);
      chk("flood win", 64'(playEnd), 64'd2);
      chk("flood shown", 64'(shown), 64'h7FFF_FFFF_FFFF_FFFF);
      applyStimulus(3'd0, 5'b0, 1'b0);
      applyStimulus(3'd2, 5'b0, 1'b0);
      applyStimulus(3'd2, 5'b10000, 1'b0);
      repeat (10) applyStimulus(3'd2, 5'b0, 1'b0);
      applyStimulus(3'd0, 5'b0, 1'b0);
      chk("abort shown", 64'(shown), 64'd0);
      chk("abort busy", 64'(busy), 64'd0);
`else
      chk("no flood shown", 64'(shown), 64'd1);
      chk("no flood busy", 64'(busy), 64'd0);
      applyStimulus(3'd2, 5'b0, 1'b0);
      chk("no flood end", 64'(playEnd), 64'd0);
      applyStimulus(3'd0, 5'b0, 1'b0);
`endif

      // Only cells 0 and 1 are safe: win shows one cycle after the last reveal.
      for (int k = 0; k < NC; k++) mineSet[k] = (k > 1);
      buildMap();
      applyStimulus(3'd2, 5'b0, 1'b0);
      press(4, 1'b0);
      press(3, 1'b0);
      applyStimulus(3'd2, 5'b10000, 1'b0);
      chk("win last shown", 64'(shown), 64'd3);
      chk("win not yet", 64'(playEnd), 64'd0);
      applyStimulus(3'd2, 5'b0, 1'b0);
      chk("win end", 64'(playEnd), 64'd2);

      // Randomized play on random maps with occasional screen changes.
      for (int g = 0; g < 8; g++) begin
         applyStimulus(3'd0, 5'b0, 1'b0);
         for (int k = 0; k < NC; k++) mineSet[k] = ($urandom_range(0, 99) < 4 + g * 3);
         buildMap();
         for (int c = 0; c < 600; c++) begin
            logic [2:0] s;
            logic [4:0] b;
            s = ($urandom_range(0, 79) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            b = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'b0;
            applyStimulus(s, b, 1'($urandom_range(0, 1)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule
